interrupt_ack_sequencer: RTL and testbench
==========================================

// Module: interrupt_ack_sequencer
// PURPOSE
//  Sequences the interrupt request register for the 8259A core. Each cycle it
//  resolves the highest-priority unmasked request against the in-service register.
//  It raises INT, runs the two-pulse INTA acknowledge, clears the serviced IRR line,
//  sets the ISR bit and presents the vector byte. It also handles EOI, automatic EOI
//  (AEOI) and priority rotation. It sits between the IRR, the control-word registers
//  and the data-bus buffer.
// PARAMETERS
//  NUM_LEVELS     8  interrupt levels; only 8 supported, width of all level vectors
//  SPURIOUS_LEVEL 7  level code returned when a request vanishes before the first INTA
// PORTS
//  clk               in   1  single clock, all state on rising edge
//  reset             in   1  synchronous, active-high
//  interrupt_req_reg in   8  IRR contents (level or edge already resolved upstream)
//  interrupt_mask    in   8  OCW1 mask; 1 = level masked
//  vector_base       in   5  ICW2 T7..T3
//  aeoi_mode         in   1  1 = clear ISR bit automatically at end of second INTA
//  inta_pulse        in   1  one-cycle strobe per INTA pulse (synchronised upstream)
//  eoi_valid         in   1  one-cycle OCW2 EOI strobe
//  eoi_specific      in   1  1 = clear eoi_level; 0 = clear highest-priority ISR bit
//  eoi_rotate        in   1  1 = the cleared level becomes lowest priority
//  eoi_level         in   3  level for specific EOI
//  set_prio_valid    in   1  one-cycle strobe: set lowest-priority level, no EOI
//  set_prio_level    in   3  new lowest-priority level
//  int_out           out  1  INT pin to CPU
//  clear_ir_line     out  8  one-hot one-cycle IRR clear pulse
//  in_service_reg    out  8  ISR
//  vector_out        out  8  {vector_base, level[2:0]}
//  vector_valid      out  1  vector_out drives the data bus
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lowest-priority pointer = 7 (IR0 highest).
//  Priority: level L outranks M if (L-ptr-1) mod 8 < (M-ptr-1) mod 8. A candidate is
//   (irr & ~mask) strictly outranking the highest set ISR bit (fully nested mode).
//  FSM:
//   IDLE: candidate exists -> int_out=1 next cycle -> PEND.
//   PEND: candidate gone before inta_pulse -> int_out=0 -> IDLE.
//     inta_pulse -> latch current winner (or SPURIOUS_LEVEL if none).
//       Real winner: set ISR bit and pulse clear_ir_line for that level, both in the
//       same cycle as the latch. Spurious: neither ISR nor IRR changes.
//     int_out=0 next cycle -> ACK1.
//   ACK1: inta_pulse -> vector_out={vector_base,latched level}, vector_valid=1 for
//     exactly 1 cycle. If aeoi_mode and not spurious, clear that ISR bit in the same
//     cycle; rotation is not applied in AEOI. -> IDLE.
//  Latency: IRR rise -> int_out is 1 cycle; 2nd INTA strobe -> vector_valid is 1 cycle.
//  Winner is frozen from the first INTA until IDLE; IRR changes do not alter it.
//  EOI is accepted in any state. Non-specific with ISR=0 is a no-op. Specific on a
//   clear bit is a no-op for ISR, but eoi_rotate still sets the pointer.
//  EOI in the same cycle as an ISR set: set takes priority on the same bit; other
//   bits clear normally.
//  eoi_rotate and set_prio_valid in the same cycle: set_prio_valid wins the pointer.
//  inta_pulse in IDLE: ignored.
//  reset mid-acknowledge: FSM to IDLE, ISR cleared, no clear_ir_line pulse,
//   vector_valid=0.
// STRUCTURE
//  pic_pkg:
//   - state enum: IDLE/PEND/ACK1
//   - NUM_LEVELS, SPURIOUS_LEVEL
//   - function rot_prio_pick(req[7:0], ptr[2:0]) -> {found, level[2:0]}
//  Sub-module priority_resolver: combinational rotating priority encoder; used twice,
//   once for the IRR candidate and once for the highest ISR bit.
// TESTING
//  1. irr=0x0C, mask=0 -> int_out@+1; INTA#1 -> ISR=0x04, clear_ir_line=0x04;
//     INTA#2 with base=0x08 -> vector 0x42.
//  2. ISR=0x04, irr=0x10 -> int_out stays 0; irr=0x02 -> int_out=1 (IR1 preempts).
//  3. Level IR5 drops between int_out and INTA#1 -> vector {base,3'd7}, ISR unchanged,
//     no clear_ir_line.
//  4. aeoi_mode=1, irr=0x01 -> after INTA#2 ISR=0x00 in same cycle as vector_valid.
//  5. ISR=0x09, non-specific EOI+rotate -> ISR=0x08, ptr=0, IR1 now highest;
//     set_prio level 3 -> IR4 highest.
//  6. reset asserted in ACK1 -> all outputs 0 next cycle; a following INTA is ignored.

Source files
------------

// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types and the rotating-priority pick used by the 8259A acknowledge path.
// Purely combinational helpers; no state and no backpressure.
package interrupt_ack_sequencer_pkg;

  localparam int         NUM_LEVELS     = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK1 = 2'd2
  } state_t;

  // ptr is the lowest-priority level, so ptr+1 is scanned as the highest.
  // Walking from lowest to highest lets the last hit be the winner.
  function automatic logic [3:0] rot_prio_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [3:0] r_pick;
    logic [2:0] r_lvl;
    r_pick = 4'd0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      r_lvl = ptr + 3'(i) + 3'd1;
      if (req[r_lvl]) r_pick = {1'b1, r_lvl};
    end
    return r_pick;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// Rotating priority encoder: highest-priority set bit of i_req relative to i_ptr.
// Combinational, zero latency, no backpressure.
module priority_resolver
  import interrupt_ack_sequencer_pkg::*;
(
  input  logic [7:0] i_req,
  input  logic [2:0] i_ptr,
  output logic       o_found,
  output logic [2:0] o_level
);

  logic [3:0] w_pick;

  assign w_pick  = rot_prio_pick(i_req, i_ptr);
  assign o_found = w_pick[3];
  assign o_level = w_pick[2:0];

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A INT/INTA sequencer with ISR, EOI/AEOI and priority rotation.
// IRR->INT and 2nd INTA->vector are 1 cycle each; no backpressure.
module interrupt_ack_sequencer
  import interrupt_ack_sequencer_pkg::*;
#(
  parameter int         NUM_LEVELS     = interrupt_ack_sequencer_pkg::NUM_LEVELS,
  parameter logic [2:0] SPURIOUS_LEVEL = interrupt_ack_sequencer_pkg::SPURIOUS_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] interrupt_req_reg,
  input  logic [NUM_LEVELS-1:0] interrupt_mask,
  input  logic [4:0]            vector_base,
  input  logic                  aeoi_mode,
  input  logic                  inta_pulse,
  input  logic                  eoi_valid,
  input  logic                  eoi_specific,
  input  logic                  eoi_rotate,
  input  logic [2:0]            eoi_level,
  input  logic                  set_prio_valid,
  input  logic [2:0]            set_prio_level,
  output logic                  int_out,
  output logic [NUM_LEVELS-1:0] clear_ir_line,
  output logic [NUM_LEVELS-1:0] in_service_reg,
  output logic [7:0]            vector_out,
  output logic                  vector_valid
);

  state_t                r_state;
  logic [2:0]            r_ptr;
  logic [2:0]            r_lvl;
  logic                  r_spur;
  logic                  r_int_out;
  logic [NUM_LEVELS-1:0] r_clr;
  logic [NUM_LEVELS-1:0] r_isr;
  logic [7:0]            r_vec;
  logic                  r_vld;

  logic [NUM_LEVELS-1:0] w_req;
  logic                  w_irr_found;
  logic [2:0]            w_irr_lvl;
  logic                  w_isr_found;
  logic [2:0]            w_isr_lvl;
  logic [2:0]            w_irr_rank;
  logic [2:0]            w_isr_rank;
  logic                  w_cand;
  logic                  w_ack_set_en;
  logic                  w_aeoi_en;
  logic [2:0]            w_eoi_lvl;
  logic                  w_eoi_hit;
  logic [NUM_LEVELS-1:0] w_set_mask;
  logic [NUM_LEVELS-1:0] w_clr_mask;
  logic [NUM_LEVELS-1:0] w_isr_nxt;

  assign w_req = interrupt_req_reg & ~interrupt_mask;

  priority_resolver u_irr_res (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_found (w_irr_found),
    .o_level (w_irr_lvl)
  );

  priority_resolver u_isr_res (
    .i_req   (r_isr),
    .i_ptr   (r_ptr),
    .o_found (w_isr_found),
    .o_level (w_isr_lvl)
  );

  // Rank 0 is the highest priority; a request must strictly beat the active ISR level.
  assign w_irr_rank = w_irr_lvl - r_ptr - 3'd1;
  assign w_isr_rank = w_isr_lvl - r_ptr - 3'd1;
  assign w_cand     = w_irr_found && (!w_isr_found || (w_irr_rank < w_isr_rank));

  assign w_ack_set_en = (r_state == PEND) && inta_pulse && w_cand;
  assign w_aeoi_en    = (r_state == ACK1) && inta_pulse && aeoi_mode && !r_spur;

  assign w_eoi_lvl = eoi_specific ? eoi_level : w_isr_lvl;
  assign w_eoi_hit = eoi_valid && (eoi_specific || w_isr_found);

  assign w_set_mask = w_ack_set_en ? (NUM_LEVELS'(1) << w_irr_lvl) : '0;
  assign w_clr_mask = (w_eoi_hit ? (NUM_LEVELS'(1) << w_eoi_lvl) : '0)
                    | (w_aeoi_en ? (NUM_LEVELS'(1) << r_lvl) : '0);

  // Setting wins over a same-cycle EOI clear of the same bit.
  assign w_isr_nxt = (r_isr & ~w_clr_mask) | w_set_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= 3'd7;
      r_lvl     <= 3'd0;
      r_spur    <= 1'b0;
      r_int_out <= 1'b0;
      r_clr     <= '0;
      r_isr     <= '0;
      r_vec     <= 8'd0;
      r_vld     <= 1'b0;
    end else begin
      r_clr <= '0;
      r_vld <= 1'b0;
      r_vec <= 8'd0;
      r_isr <= w_isr_nxt;

      if (set_prio_valid) begin
        r_ptr <= set_prio_level;
      end else if (w_eoi_hit && eoi_rotate) begin
        r_ptr <= w_eoi_lvl;
      end

      case (r_state)
        IDLE: begin
          if (w_cand) begin
            r_int_out <= 1'b1;
            r_state   <= PEND;
          end
        end
        PEND: begin
          if (inta_pulse) begin
            r_int_out <= 1'b0;
            r_state   <= ACK1;
            if (w_cand) begin
              r_lvl  <= w_irr_lvl;
              r_spur <= 1'b0;
              r_clr  <= NUM_LEVELS'(1) << w_irr_lvl;
            end else begin
              r_lvl  <= SPURIOUS_LEVEL;
              r_spur <= 1'b1;
            end
          end else if (!w_cand) begin
            r_int_out <= 1'b0;
            r_state   <= IDLE;
          end
        end
        ACK1: begin
          if (inta_pulse) begin
            r_vec   <= {vector_base, r_lvl};
            r_vld   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_int_out <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign int_out        = r_int_out;
  assign clear_ir_line  = r_clr;
  assign in_service_reg = r_isr;
  assign vector_out     = r_vec;
  assign vector_valid   = r_vld;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: acknowledge, nesting, spurious, AEOI, rotation, reset.
module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] interrupt_req_reg;
  logic [7:0] interrupt_mask;
  logic [4:0] vector_base;
  logic       aeoi_mode;
  logic       inta_pulse;
  logic       eoi_valid;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic       set_prio_valid;
  logic [2:0] set_prio_level;
  logic       int_out;
  logic [7:0] clear_ir_line;
  logic [7:0] in_service_reg;
  logic [7:0] vector_out;
  logic       vector_valid;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_ack_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .interrupt_req_reg (interrupt_req_reg),
    .interrupt_mask    (interrupt_mask),
    .vector_base       (vector_base),
    .aeoi_mode         (aeoi_mode),
    .inta_pulse        (inta_pulse),
    .eoi_valid         (eoi_valid),
    .eoi_specific      (eoi_specific),
    .eoi_rotate        (eoi_rotate),
    .eoi_level         (eoi_level),
    .set_prio_valid    (set_prio_valid),
    .set_prio_level    (set_prio_level),
    .int_out           (int_out),
    .clear_ir_line     (clear_ir_line),
    .in_service_reg    (in_service_reg),
    .vector_out        (vector_out),
    .vector_valid      (vector_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; interrupt_req_reg = 8'h00; interrupt_mask = 8'h00; vector_base = 5'h08;
    aeoi_mode = 0; inta_pulse = 0; eoi_valid = 0; eoi_specific = 0; eoi_rotate = 0;
    eoi_level = 0; set_prio_valid = 0; set_prio_level = 0;
    tick(); tick();
    n_checks++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL reset_int got %b want 0", int_out); end
    n_checks++; if (in_service_reg !== 8'h00) begin n_fail++; $display("FAIL reset_isr got %h want 00", in_service_reg); end
    n_checks++; if (clear_ir_line !== 8'h00) begin n_fail++; $display("FAIL reset_clr got %h want 00", clear_ir_line); end
    n_checks++; if ({vector_valid, vector_out} !== 9'h000) begin n_fail++; $display("FAIL reset_vec got %b/%h want 0/00", vector_valid, vector_out); end
    reset = 1'b0;
    inta_pulse = 1; tick(); inta_pulse = 0;
    n_checks++; if ({int_out, in_service_reg, clear_ir_line} !== 17'h0) begin n_fail++; $display("FAIL idle_inta_ignored got %b/%h/%h want 0/00/00", int_out, in_service_reg, clear_ir_line); end
  endtask

  task automatic test_basic_ack();
    interrupt_req_reg = 8'h0C; tick();
    n_checks++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL basic_int got %b want 1", int_out); end
    inta_pulse = 1; tick(); inta_pulse = 0; interrupt_req_reg = 8'h08;
    n_checks++; if (in_service_reg !== 8'h04) begin n_fail++; $display("FAIL basic_isr got %h want 04", in_service_reg); end
    n_checks++; if (clear_ir_line !== 8'h04) begin n_fail++; $display("FAIL basic_clr got %h want 04", clear_ir_line); end
    n_checks++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL basic_int_drop got %b want 0", int_out); end
    inta_pulse = 1; tick(); inta_pulse = 0;
    n_checks++; if ({vector_valid, vector_out} !== {1'b1, 8'h42}) begin n_fail++; $display("FAIL basic_vec got %b/%h want 1/42", vector_valid, vector_out); end
    n_checks++; if (clear_ir_line !== 8'h00) begin n_fail++; $display("FAIL basic_clr_once got %h want 00", clear_ir_line); end
    tick();
    n_checks++; if ({vector_valid, int_out} !== 2'b00) begin n_fail++; $display("FAIL basic_vld_1cyc got %b want 00", {vector_valid, int_out}); end
  endtask

  task automatic test_preempt();
    interrupt_req_reg = 8'h10; tick(); tick();
    n_checks++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL nested_block got %b want 0", int_out); end
    interrupt_req_reg = 8'h12; tick();
    n_checks++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL preempt_int got %b want 1", int_out); end
    inta_pulse = 1; tick(); inta_pulse = 0; interrupt_req_reg = 8'h10;
    n_checks++; if ({in_service_reg, clear_ir_line} !== 16'h0602) begin n_fail++; $display("FAIL preempt_ack got %h/%h want 06/02", in_service_reg, clear_ir_line); end
    inta_pulse = 1; tick(); inta_pulse = 0; interrupt_req_reg = 8'h00;
    n_checks++; if ({vector_valid, vector_out} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL preempt_vec got %b/%h want 1/41", vector_valid, vector_out); end
    eoi_valid = 1; eoi_specific = 0; tick();
    n_checks++; if (in_service_reg !== 8'h04) begin n_fail++; $display("FAIL ns_eoi1 got %h want 04", in_service_reg); end
    tick();
    n_checks++; if (in_service_reg !== 8'h00) begin n_fail++; $display("FAIL ns_eoi2 got %h want 00", in_service_reg); end
    tick(); eoi_valid = 0;
    n_checks++; if (in_service_reg !== 8'h00) begin n_fail++; $display("FAIL ns_eoi_empty got %h want 00", in_service_reg); end
  endtask

  task automatic test_spurious();
    interrupt_req_reg = 8'h20; tick();
    n_checks++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL spur_int got %b want 1", int_out); end
    interrupt_req_reg = 8'h00; inta_pulse = 1; tick(); inta_pulse = 0;
    n_checks++; if ({int_out, in_service_reg, clear_ir_line} !== 17'h0) begin n_fail++; $display("FAIL spur_ack got %b/%h/%h want 0/00/00", int_out, in_service_reg, clear_ir_line); end
    inta_pulse = 1; tick(); inta_pulse = 0;
    n_checks++; if ({vector_valid, vector_out} !== {1'b1, 8'h47}) begin n_fail++; $display("FAIL spur_vec got %b/%h want 1/47", vector_valid, vector_out); end
    n_checks++; if (in_service_reg !== 8'h00) begin n_fail++; $display("FAIL spur_isr got %h want 00", in_service_reg); end
  endtask

  task automatic test_aeoi();
    aeoi_mode = 1; interrupt_req_reg = 8'h01; tick();
    inta_pulse = 1; tick(); inta_pulse = 0; interrupt_req_reg = 8'h00;
    n_checks++; if ({in_service_reg, clear_ir_line} !== 16'h0101) begin n_fail++; $display("FAIL aeoi_ack got %h/%h want 01/01", in_service_reg, clear_ir_line); end
    inta_pulse = 1; tick(); inta_pulse = 0;
    n_checks++; if ({vector_valid, vector_out, in_service_reg} !== {1'b1, 8'h40, 8'h00}) begin n_fail++; $display("FAIL aeoi_vec got %b/%h/%h want 1/40/00", vector_valid, vector_out, in_service_reg); end
    aeoi_mode = 0; tick();
  endtask

  task automatic test_rotate();
    interrupt_req_reg = 8'h08; tick();
    inta_pulse = 1; tick(); interrupt_req_reg = 8'h00; tick(); inta_pulse = 0;
    interrupt_req_reg = 8'h01; tick();
    n_checks++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL rot_ir0_preempt got %b want 1", int_out); end
    inta_pulse = 1; tick(); interrupt_req_reg = 8'h00; tick(); inta_pulse = 0;
    n_checks++; if (in_service_reg !== 8'h09) begin n_fail++; $display("FAIL rot_isr09 got %h want 09", in_service_reg); end
    eoi_valid = 1; eoi_specific = 0; eoi_rotate = 1; tick(); eoi_valid = 0; eoi_rotate = 0;
    n_checks++; if (in_service_reg !== 8'h08) begin n_fail++; $display("FAIL rot_eoi got %h want 08", in_service_reg); end
    interrupt_req_reg = 8'h03; tick();
    n_checks++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL rot_int got %b want 1", int_out); end
    inta_pulse = 1; tick(); inta_pulse = 0; interrupt_req_reg = 8'h01;
    n_checks++; if ({in_service_reg, clear_ir_line} !== 16'h0A02) begin n_fail++; $display("FAIL rot_ir1_top got %h/%h want 0A/02", in_service_reg, clear_ir_line); end
    inta_pulse = 1; tick(); inta_pulse = 0; interrupt_req_reg = 8'h00;
    n_checks++; if ({vector_valid, vector_out} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL rot_vec got %b/%h want 1/41", vector_valid, vector_out); end
    eoi_valid = 1; eoi_specific = 1; eoi_level = 3'd1; tick();
    eoi_level = 3'd3; tick(); eoi_valid = 0;
    n_checks++; if (in_service_reg !== 8'h00) begin n_fail++; $display("FAIL spec_eoi got %h want 00", in_service_reg); end
    // Specific rotate on a clear bit (ptr->5) collides with set_prio 3; set_prio must win.
    eoi_valid = 1; eoi_specific = 1; eoi_rotate = 1; eoi_level = 3'd5;
    set_prio_valid = 1; set_prio_level = 3'd3; tick();
    eoi_valid = 0; eoi_rotate = 0; set_prio_valid = 0;
    n_checks++; if (in_service_reg !== 8'h00) begin n_fail++; $display("FAIL spec_eoi_clear_bit got %h want 00", in_service_reg); end
    interrupt_req_reg = 8'h11; tick();
    inta_pulse = 1; tick(); inta_pulse = 0; interrupt_req_reg = 8'h01;
    n_checks++; if (clear_ir_line !== 8'h10) begin n_fail++; $display("FAIL setprio_ir4_top got %h want 10", clear_ir_line); end
    inta_pulse = 1; tick(); inta_pulse = 0; interrupt_req_reg = 8'h00;
    n_checks++; if ({vector_valid, vector_out} !== {1'b1, 8'h44}) begin n_fail++; $display("FAIL setprio_vec got %b/%h want 1/44", vector_valid, vector_out); end
  endtask

  task automatic test_eoi_collision();
    do_reset();
    interrupt_req_reg = 8'h04; tick();
    inta_pulse = 1; eoi_valid = 1; eoi_specific = 1; eoi_level = 3'd2; tick();
    inta_pulse = 0; eoi_valid = 0; interrupt_req_reg = 8'h00;
    n_checks++; if (in_service_reg !== 8'h04) begin n_fail++; $display("FAIL collide_set_wins got %h want 04", in_service_reg); end
    inta_pulse = 1; tick(); inta_pulse = 0;
    n_checks++; if ({vector_valid, vector_out} !== {1'b1, 8'h42}) begin n_fail++; $display("FAIL collide_vec got %b/%h want 1/42", vector_valid, vector_out); end
  endtask

  task automatic test_reset_mid_ack();
    interrupt_req_reg = 8'h01; tick();
    inta_pulse = 1; tick(); inta_pulse = 0; interrupt_req_reg = 8'h00;
    n_checks++; if (in_service_reg !== 8'h05) begin n_fail++; $display("FAIL mid_pre_isr got %h want 05", in_service_reg); end
    reset = 1; tick(); reset = 0;
    n_checks++; if ({int_out, clear_ir_line, in_service_reg, vector_out, vector_valid} !== 26'h0) begin n_fail++; $display("FAIL mid_reset got %b/%h/%h/%h/%b want all 0", int_out, clear_ir_line, in_service_reg, vector_out, vector_valid); end
    inta_pulse = 1; tick(); inta_pulse = 0;
    n_checks++; if ({vector_valid, in_service_reg} !== 9'h000) begin n_fail++; $display("FAIL mid_inta_ignored got %b/%h want 0/00", vector_valid, in_service_reg); end
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_preempt();
    test_spurious();
    test_aeoi();
    test_rotate();
    test_eoi_collision();
    test_reset_mid_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
